// File: rtl/digit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digit_pkg
//  Description : Shared types and default frame geometry for the digit
//                bounding-box detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package digit_pkg;

    // Default active frame geometry (pixels per line, lines per frame)
    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

    // Pixel coordinate as delivered by the timing generator
    typedef logic [11:0] coord_t;

    // Frame-tracking state machine
    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        BLANK  = 2'd3
    } bbox_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Registers a 1-bit input once and produces registered,
//                single-cycle rise/fall pulses (1 clk after the transition).
//  Ports       : tft_vclk  in  clock
//                rst_n     in  asynchronous active-low reset
//                i_d       in  level to watch
//                o_rise    out pulse, i_d went 0->1
//                o_fall    out pulse, i_d went 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det (
    input  logic tft_vclk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge tft_vclk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_q    <= i_d;
            r_rise <= i_d & ~r_q;
            r_fall <= ~i_d & r_q;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/digit_bbox_detect.sv
`default_nettype none
// ============================================================================
//  Module      : digit_bbox_detect
//  Description : Finds the bounding box of all foreground (th_flag=1) pixels
//                of each frame and publishes it on the rising edge of tft_vs,
//                together with th_flag/tft_vs edge pulses and a 3-bit frame
//                counter.
//  Ports       : tft_vclk, rst_n (async, active-low)
//                tft_de, tft_vs, th_flag, hcount[11:0], vcount[11:0]  in
//                hcount_l/r, vcount_l/r [11:0]  box of last completed frame
//                bbox_valid   last completed frame had foreground
//                th_flag_rise/fall, tft_vs_rise/fall  1-clk edge pulses
//                frame_cnt[2:0]  committed frames, modulo 8
//  Options     : BBOX_RUNFILT_EN - only count foreground runs of at least
//                RUN_MIN consecutive pixels within a line.
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_bbox_detect
    import digit_pkg::*;
#(
    parameter int H_ACT   = H_ACT_DEF,
    parameter int V_ACT   = V_ACT_DEF
`ifdef BBOX_RUNFILT_EN
    ,
    parameter int RUN_MIN = 3
`endif
) (
    input  logic       tft_vclk,
    input  logic       rst_n,
    input  logic       tft_de,
    input  logic       tft_vs,
    input  logic       th_flag,
    input  coord_t     hcount,
    input  coord_t     vcount,
    output coord_t     hcount_l,
    output coord_t     hcount_r,
    output coord_t     vcount_l,
    output coord_t     vcount_r,
    output logic       bbox_valid,
    output logic       th_flag_rise,
    output logic       th_flag_fall,
    output logic       tft_vs_rise,
    output logic       tft_vs_fall,
    output logic [2:0] frame_cnt
);

    localparam coord_t c_h_act = coord_t'(H_ACT);
    localparam coord_t c_v_act = coord_t'(V_ACT);

    bbox_state_t r_state, w_state_nxt;
    logic        w_commit, w_clear;
    logic        r_vs_d;
    logic        w_vs_rise, w_vs_fall;
    logic        w_run_ok, w_take;
    coord_t      w_left_x;

    coord_t      r_min_x, r_max_x, r_min_y, r_max_y;
    logic        r_hit;
    coord_t      r_hcount_l, r_hcount_r, r_vcount_l, r_vcount_r;
    logic        r_bbox_valid;
    logic [2:0]  r_frame_cnt;

    // Published edge pulses
    sync_edge_det u_th_edge (
        .tft_vclk (tft_vclk),
        .rst_n    (rst_n),
        .i_d      (th_flag),
        .o_rise   (th_flag_rise),
        .o_fall   (th_flag_fall)
    );

    sync_edge_det u_vs_edge (
        .tft_vclk (tft_vclk),
        .rst_n    (rst_n),
        .i_d      (tft_vs),
        .o_rise   (tft_vs_rise),
        .o_fall   (tft_vs_fall)
    );

    // Local previous-vs level: the FSM needs the unregistered edge so the
    // commit lands on the same clock edge that raises tft_vs_rise.
    always_ff @(posedge tft_vclk or negedge rst_n) begin
        if (!rst_n) r_vs_d <= 1'b0;
        else        r_vs_d <= tft_vs;
    end

    assign w_vs_rise = tft_vs & ~r_vs_d;
    assign w_vs_fall = ~tft_vs & r_vs_d;

`ifdef BBOX_RUNFILT_EN
    localparam int                 c_run_w    = $clog2(RUN_MIN + 1);
    localparam logic [c_run_w-1:0] c_run_full = c_run_w'(RUN_MIN);
    localparam logic [c_run_w-1:0] c_run_one  = c_run_w'(1);

    logic [c_run_w-1:0] r_run, w_run_nxt;
    coord_t             r_vcount_d;

    // Saturating run length of consecutive foreground de pixels in one line
    always_comb begin
        w_run_nxt = '0;
        if (tft_de && th_flag) begin
            if (vcount != r_vcount_d)     w_run_nxt = c_run_one;
            else if (r_run == c_run_full) w_run_nxt = r_run;
            else                          w_run_nxt = r_run + c_run_one;
        end
    end

    always_ff @(posedge tft_vclk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= '0;
            r_vcount_d <= '0;
        end else begin
            r_run      <= w_run_nxt;
            r_vcount_d <= vcount;
        end
    end

    // Once the run is long enough, its true start lies RUN_MIN-1 pixels back
    assign w_run_ok = (w_run_nxt == c_run_full);
    assign w_left_x = hcount - coord_t'(RUN_MIN - 1);
`else
    assign w_run_ok = 1'b1;
    assign w_left_x = hcount;
`endif

    assign w_take = (r_state == SCAN) && tft_de && th_flag && w_run_ok
                 && (hcount < c_h_act) && (vcount < c_v_act);

    // FSM: state register
    always_ff @(posedge tft_vclk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT;
        else        r_state <= w_state_nxt;
    end

    // FSM: next state; results are latched on the edge entering COMMIT
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            WAIT: begin
                w_clear = 1'b1;
                if (w_vs_fall) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (w_vs_rise) begin
                    w_state_nxt = COMMIT;
                    w_commit    = 1'b1;
                end
            end
            COMMIT: w_state_nxt = BLANK;
            BLANK: begin
                w_clear = 1'b1;
                if (w_vs_fall) w_state_nxt = SCAN;
            end
            default: w_state_nxt = WAIT;
        endcase
    end

    // Accumulators
    always_ff @(posedge tft_vclk or negedge rst_n) begin
        if (!rst_n) begin
            r_min_x <= 12'hFFF;
            r_max_x <= '0;
            r_min_y <= 12'hFFF;
            r_max_y <= '0;
            r_hit   <= 1'b0;
        end else if (w_clear) begin
            r_min_x <= 12'hFFF;
            r_max_x <= '0;
            r_min_y <= 12'hFFF;
            r_max_y <= '0;
            r_hit   <= 1'b0;
        end else if (w_take) begin
            if (w_left_x < r_min_x) r_min_x <= w_left_x;
            if (hcount > r_max_x)   r_max_x <= hcount;
            if (vcount < r_min_y)   r_min_y <= vcount;
            if (vcount > r_max_y)   r_max_y <= vcount;
            r_hit <= 1'b1;
        end
    end

    // Published results; an empty frame keeps the previous coordinates
    always_ff @(posedge tft_vclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount_l   <= '0;
            r_hcount_r   <= '0;
            r_vcount_l   <= '0;
            r_vcount_r   <= '0;
            r_bbox_valid <= 1'b0;
            r_frame_cnt  <= '0;
        end else if (w_commit) begin
            if (r_hit) begin
                r_hcount_l <= r_min_x;
                r_hcount_r <= r_max_x;
                r_vcount_l <= r_min_y;
                r_vcount_r <= r_max_y;
            end
            r_bbox_valid <= r_hit;
            r_frame_cnt  <= r_frame_cnt + 3'd1;
        end
    end

    assign hcount_l   = r_hcount_l;
    assign hcount_r   = r_hcount_r;
    assign vcount_l   = r_vcount_l;
    assign vcount_r   = r_vcount_r;
    assign bbox_valid = r_bbox_valid;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_digit_bbox_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_bbox_detect
//  Description : Randomised self-checking bench for digit_bbox_detect with a
//                frame-level reference model and a commit scoreboard.
//                Honours BBOX_RUNFILT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_bbox_detect;
    import digit_pkg::*;

    localparam int H_ACT   = 640;
    localparam int V_ACT   = 480;
    localparam int RUN_MIN = 3;
`ifdef BBOX_RUNFILT_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       tft_vclk = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tft_de   = 1'b0;
    logic       tft_vs   = 1'b0;
    logic       th_flag  = 1'b0;
    coord_t     hcount   = '0;
    coord_t     vcount   = '0;
    coord_t     hcount_l, hcount_r, vcount_l, vcount_r;
    logic       bbox_valid, th_flag_rise, th_flag_fall, tft_vs_rise, tft_vs_fall;
    logic [2:0] frame_cnt;

    always #5 tft_vclk = ~tft_vclk;

    digit_bbox_detect #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) dut (
        .tft_vclk     (tft_vclk),
        .rst_n        (rst_n),
        .tft_de       (tft_de),
        .tft_vs       (tft_vs),
        .th_flag      (th_flag),
        .hcount       (hcount),
        .vcount       (vcount),
        .hcount_l     (hcount_l),
        .hcount_r     (hcount_r),
        .vcount_l     (vcount_l),
        .vcount_r     (vcount_r),
        .bbox_valid   (bbox_valid),
        .th_flag_rise (th_flag_rise),
        .th_flag_fall (th_flag_fall),
        .tft_vs_rise  (tft_vs_rise),
        .tft_vs_fall  (tft_vs_fall),
        .frame_cnt    (frame_cnt)
    );

    typedef struct {
        logic [11:0] l, r, t, b;
        logic        valid;
        logic [2:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- reference model (frame level) ----------------
    bit   m_scan, m_hit, m_vs_prev;
    int   m_minx, m_maxx, m_miny, m_maxy;
    exp_t m_out;

    function automatic void model_reset();
        m_scan    = 1'b0;
        m_hit     = 1'b0;
        m_vs_prev = 1'b0;
        m_out     = '{default: 0};
        q.delete();
    endfunction

    // pos = index of this pixel within its contiguous foreground run
    function automatic void model_pixel(input int x, input int y, input int pos);
        int left;
        if (!m_scan || x >= H_ACT || y >= V_ACT) return;
        if (FILT && pos < RUN_MIN - 1) return;
        left = FILT ? x - (RUN_MIN - 1) : x;
        if (left < m_minx) m_minx = left;
        if (x > m_maxx)    m_maxx = x;
        if (y < m_miny)    m_miny = y;
        if (y > m_maxy)    m_maxy = y;
        m_hit = 1'b1;
    endfunction

    task automatic drive(input logic de, input logic th, input logic vs, input int h, input int v);
        @(posedge tft_vclk);
        #1;
        tft_de  = de;
        th_flag = th;
        tft_vs  = vs;
        hcount  = 12'(h);
        vcount  = 12'(v);
        if (vs && !m_vs_prev) begin
            if (m_scan) begin
                m_scan = 1'b0;
                if (m_hit) begin
                    m_out.l = 12'(m_minx);
                    m_out.r = 12'(m_maxx);
                    m_out.t = 12'(m_miny);
                    m_out.b = 12'(m_maxy);
                end
                m_out.valid = m_hit;
                m_out.cnt   = m_out.cnt + 3'd1;
            end
            q.push_back(m_out);
        end else if (!vs && m_vs_prev) begin
            m_scan = 1'b1;
            m_hit  = 1'b0;
            m_minx = 4095; m_maxx = 0;
            m_miny = 4095; m_maxy = 0;
        end
        m_vs_prev = vs;
    endtask

    task automatic gap(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic run(input int x0, input int y, input int len);
        for (int i = 0; i < len; i++) begin
            drive(1'b1, 1'b1, 1'b0, x0 + i, y);
            model_pixel(x0 + i, y, i);
        end
        gap(1);
    endtask

    task automatic frame_start();
        repeat (3) drive(1'b0, 1'b0, 1'b1, 0, 0);
        gap(3);
    endtask

    task automatic do_reset();
        @(posedge tft_vclk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #2;
        check("reset_outputs",
              {hcount_l, hcount_r, vcount_l, vcount_r, bbox_valid, th_flag_rise,
               th_flag_fall, tft_vs_rise, tft_vs_fall, frame_cnt}, 64'd0);
        repeat (3) @(posedge tft_vclk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t cur = '{default: 0};
    logic p_th = 1'b0, p_vs = 1'b0;
    logic e_tr = 1'b0, e_tf = 1'b0, e_vr = 1'b0, e_vf = 1'b0;
    int   pulse_err = 0;
    int   stab_err  = 0;

    initial begin
        forever begin
            @(posedge tft_vclk);
            if (!rst_n) begin
                p_th = 1'b0; p_vs = 1'b0;
                e_tr = 1'b0; e_tf = 1'b0; e_vr = 1'b0; e_vf = 1'b0;
            end else begin
                e_tr = th_flag & ~p_th;
                e_tf = ~th_flag & p_th;
                e_vr = tft_vs & ~p_vs;
                e_vf = ~tft_vs & p_vs;
                p_th = th_flag;
                p_vs = tft_vs;
            end
            @(negedge tft_vclk);
            if (!rst_n) begin
                cur = '{default: 0};
                continue;
            end
            if ({th_flag_rise, th_flag_fall, tft_vs_rise, tft_vs_fall} !== {e_tr, e_tf, e_vr, e_vf})
                pulse_err++;
            if (tft_vs_rise) begin
                if (q.size() == 0) begin
                    check("unexpected_vs_rise", 64'd1, 64'd0);
                end else begin
                    cur = q.pop_front();
                    check("hcount_l",   hcount_l,   cur.l);
                    check("hcount_r",   hcount_r,   cur.r);
                    check("vcount_l",   vcount_l,   cur.t);
                    check("vcount_r",   vcount_r,   cur.b);
                    check("bbox_valid", bbox_valid, cur.valid);
                    check("frame_cnt",  frame_cnt,  cur.cnt);
                    check("edge_pulses", pulse_err, 0);
                    check("stable_between_commits", stab_err, 0);
                    pulse_err = 0;
                    stab_err  = 0;
                end
            end else if ({hcount_l, hcount_r, vcount_l, vcount_r, bbox_valid, frame_cnt} !==
                         {cur.l, cur.r, cur.t, cur.b, cur.valid, cur.cnt}) begin
                stab_err++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (2) @(posedge tft_vclk);
        #1;
        check("reset_outputs",
              {hcount_l, hcount_r, vcount_l, vcount_r, bbox_valid, th_flag_rise,
               th_flag_fall, tft_vs_rise, tft_vs_fall, frame_cnt}, 64'd0);
        rst_n = 1'b1;

        // Partial frame interrupted by reset; the next frame is discarded
        frame_start();
        run(300, 200, 4);
        do_reset();
        run(100, 50, 1);
        run(400, 10, 3);
        frame_start();
        // Two frames with a single pixel at (100,50)
        run(100, 50, 1);
        frame_start();
        run(100, 50, 1);
        frame_start();
        // Rectangle x 200..260, y 120..300
        run(200, 120, 61);
        run(230, 200, 1);
        run(240, 250, 5);
        run(200, 300, 61);
        // Empty frame
        frame_start();
        gap(10);
        // Out-of-area and de=0 foreground only
        frame_start();
        run(700, 60, 4);
        drive(1'b0, 1'b1, 1'b0, 50, 50);
        gap(1);
        run(20, 490, 4);
        // Isolated 2-pixel run and a 5-pixel run
        frame_start();
        run(10, 5, 2);
        run(30, 6, 5);
        // Random frames
        for (int f = 0; f < 14; f++) begin
            frame_start();
            for (int k = $urandom_range(0, 6); k > 0; k--) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive(1'b0, 1'b1, 1'b0, $urandom_range(0, 700), $urandom_range(0, 500));
                    gap(1);
                end else begin
                    run($urandom_range(2, 719), $urandom_range(0, 519), $urandom_range(1, 6));
                end
            end
        end
        frame_start();
        gap(5);
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound
    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete, got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
